// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial pattern transmitter with start/ready handshake, hold and done pulse.
// Ports: CLK/RESET (async active-high), start/pattern/len request (len 0 or >WIDTH sends WIDTH bits),
// hold pauses shifting, ready (IDLE), x/x_valid serial data, done one-cycle pulse, S state code.
// Optional: define SERIAL_PATTERN_TX_REPEAT_EN to add input rpt ("repeat" is a reserved word), which
// reloads the captured pattern after the last bit instead of entering DONE.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             hold,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    input  logic             rpt,
`endif
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [1:0]       S
);
    localparam logic [1:0] IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10;
    logic [WIDTH-1:0] sr, al;
    logic [CNT_W-1:0] cnt, l;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    logic [WIDTH-1:0] cap;
    logic [CNT_W-1:0] lcap;
`endif
    // Left-align the L-bit pattern so bit L-1 sits at the MSB and shifting left walks down to bit 0.
    always_comb begin
        l  = (len == '0 || len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;
        al = pattern << (CNT_W'(WIDTH) - l);
    end
    assign ready   = (S == IDLE);
    assign x_valid = (S == SHIFT);
    assign done    = (S == DONE);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            S   <= IDLE;
            x   <= 1'b0;
            sr  <= '0;
            cnt <= '0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            cap  <= '0;
            lcap <= '0;
`endif
        end else begin
            case (S)
                IDLE: if (start) begin
                    S   <= SHIFT;
                    x   <= al[WIDTH-1];
                    sr  <= al << 1;
                    cnt <= l;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                    cap  <= al;
                    lcap <= l;
`endif
                end
                SHIFT: if (!hold) begin
                    // cnt counts bits still to be shown including the current one
                    if (cnt > CNT_W'(1)) begin
                        x   <= sr[WIDTH-1];
                        sr  <= sr << 1;
                        cnt <= cnt - CNT_W'(1);
                    end
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                    else if (rpt) begin
                        x   <= cap[WIDTH-1];
                        sr  <= cap << 1;
                        cnt <= lcap;
                    end
`endif
                    else begin
                        S   <= DONE;
                        x   <= 1'b0;
                        cnt <= '0;
                    end
                end
                default: begin
                    S <= IDLE;
                    x <= 1'b0;
                end
            endcase
        end
    end
endmodule
